// File: rtl/router_pkt_src.sv
// Router ingress packet source: buffers a payload, sends header/data/parity,
// then samples the router error flag. Optional STATS_EN adds packet counters.
module router_pkt_src #(
  parameter int DEPTH   = 64,
  parameter int CHK_CYC = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  output logic       cmd_drop,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  input  logic       error,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       done,
  output logic       done_err
`ifdef STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (CHK_CYC > 1) ? $clog2(CHK_CYC) : 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] HDR  = 3'd2;
  localparam logic [2:0] DATA = 3'd3;
  localparam logic [2:0] PAR  = 3'd4;
  localparam logic [2:0] CHK  = 3'd5;

  logic [2:0]    state;
  logic [1:0]    addr;
  logic [5:0]    len;
  logic [7:0]    parity;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] chk_cnt;
  logic          flag;
  logic [7:0]    mem [DEPTH];

  logic cmd_acc;
  logic cmd_bad;
  logic pl_acc;
  logic load_last;
  logic data_last;
  logic chk_last;

  assign cmd_acc   = cmd_valid & cmd_ready;
  assign cmd_bad   = (cmd_addr == 2'd3) | (cmd_len == 6'd0);
  assign pl_acc    = pl_valid & pl_ready;
  assign load_last = (wptr + AW'(1)) == AW'(len);
  assign data_last = rptr == AW'(len);
  assign chk_last  = chk_cnt == CW'(CHK_CYC - 1);

  // payload store; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (pl_acc) mem[wptr] <= pl_data;
  end

  // packet sequencing: load, header, data, parity, error check
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      addr      <= '0;
      len       <= '0;
      parity    <= '0;
      wptr      <= '0;
      rptr      <= '0;
      chk_cnt   <= '0;
      flag      <= 1'b0;
      cmd_ready <= 1'b0;
      cmd_drop  <= 1'b0;
      pl_ready  <= 1'b0;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
    end else begin
      cmd_drop <= 1'b0;
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_acc) begin
            cmd_ready <= 1'b0;
            if (cmd_bad) begin
              cmd_drop <= 1'b1;
            end else begin
              addr     <= cmd_addr;
              len      <= cmd_len;
              parity   <= '0;
              wptr     <= '0;
              rptr     <= '0;
              pl_ready <= 1'b1;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (pl_acc) begin
            wptr   <= wptr + AW'(1);
            parity <= parity ^ pl_data;
            if (load_last) begin
              pl_ready  <= 1'b0;
              pkt_data  <= {len, addr};
              pkt_valid <= 1'b1;
              state     <= HDR;
            end
          end
        end
        HDR: begin
          if (!busy) begin
            parity   <= parity ^ pkt_data;
            pkt_data <= mem[rptr];
            rptr     <= rptr + AW'(1);
            state    <= DATA;
          end
        end
        DATA: begin
          if (!busy) begin
            if (data_last) begin
              pkt_data  <= parity;
              pkt_valid <= 1'b0;
              state     <= PAR;
            end else begin
              pkt_data <= mem[rptr];
              rptr     <= rptr + AW'(1);
            end
          end
        end
        PAR: begin
          if (!busy) begin
            pkt_data <= '0;
            chk_cnt  <= '0;
            flag     <= 1'b0;
            state    <= CHK;
          end
        end
        CHK: begin
          flag    <= flag | error;
          chk_cnt <= chk_cnt + CW'(1);
          if (chk_last) begin
            done      <= 1'b1;
            done_err  <= flag | error;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STATS_EN
  // saturating totals of completed and errored packets
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (done) begin
      if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      if (done_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_pkt_src.sv
// Randomised scoreboard bench for router_pkt_src.
// Expected wire bytes and status come from a packet-level model.
module tb_router_pkt_src;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic       cmd_drop;
  logic       pl_valid = 1'b0;
  logic       pl_ready;
  logic [7:0] pl_data = '0;
  logic       busy = 1'b0;
  logic       error = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       done;
  logic       done_err;
`ifdef STATS_EN
  logic [15:0] pkt_cnt;
  logic [15:0] err_cnt;
`endif

  router_pkt_src #(.DEPTH(64), .CHK_CYC(3)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_drop(cmd_drop),
    .pl_valid(pl_valid), .pl_ready(pl_ready),
    .pl_data(pl_data),
    .busy(busy), .error(error),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid),
    .done(done), .done_err(done_err)
`ifdef STATS_EN
    , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] data;
    logic       is_par;
  } wb_t;

  wb_t wq[$];
  bit  eq[$];

  int tests = 0;
  int fails = 0;
  int drops_exp = 0;
  int drops_seen = 0;
  int done_seen = 0;
  int done_exp = 0;
  int errs_exp = 0;
  bit in_pkt = 0;
  bit chk_pending = 0;
  bit err_en = 0;
  bit busy_rand = 0;
  bit noise_en = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // scoreboard monitor: compares every presented byte and status pulse
  always @(negedge clock) begin
    if (resetn) begin
      if (pkt_valid || in_pkt) begin
        if (wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wire_extra: got %h valid %b, expected nothing",
                   pkt_data, pkt_valid);
        end else begin
          chk("wire_valid", 32'(pkt_valid), 32'(!wq[0].is_par));
          chk("wire_data", 32'(pkt_data), 32'(wq[0].data));
          if (!busy) begin
            in_pkt = !wq[0].is_par;
            if (wq[0].is_par) chk_pending = 1;
            void'(wq.pop_front());
          end
        end
      end
      if (cmd_drop) drops_seen++;
      if (done) begin
        if (eq.size() == 0) fail_now("done_extra");
        else chk("done_err", 32'(done_err), 32'(eq.pop_front()));
        done_seen++;
        chk_pending = 0;
      end
    end
  end

  // error stimulus: the packet's error mode during CHK, noise elsewhere
  always @(posedge clock) begin
    #2;
    if (chk_pending) error = err_en;
    else if (noise_en) error = 1'($urandom % 2);
    else error = 1'b0;
  end

  // random backpressure
  always @(posedge clock) begin
    #1;
    if (busy_rand) busy = ($urandom % 3) == 0;
  end

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
    bit hs;
    int n = 0;
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1'b1;
    forever begin
      hs = cmd_ready;
      @(posedge clock);
      #1;
      if (hs) break;
      if (++n > 200) begin
        fail_now("cmd_timeout");
        break;
      end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [7:0] pay[$], input bit tog);
    bit hs;
    int i = 0;
    int n = 0;
    while (i < pay.size()) begin
      pl_data = pay[i];
      pl_valid = tog ? 1'($urandom % 2) : 1'b1;
      hs = pl_valid & pl_ready;
      @(posedge clock);
      #1;
      if (hs) i++;
      if (++n > 2000) begin
        fail_now("payload_timeout");
        break;
      end
    end
    pl_valid = 1'b0;
  endtask

  // model: header = len*4+addr, parity = XOR of header and payload
  task automatic start_pkt(input logic [1:0] a, input logic [5:0] l,
                           input logic [7:0] pay[$],
                           input bit tog, input bit err);
    logic [7:0] hdr;
    logic [7:0] par;
    hdr = 8'(int'(l) * 4 + int'(a));
    par = hdr;
    wq.push_back('{data: hdr, is_par: 1'b0});
    foreach (pay[i]) begin
      par = par ^ pay[i];
      wq.push_back('{data: pay[i], is_par: 1'b0});
    end
    wq.push_back('{data: par, is_par: 1'b1});
    eq.push_back(err);
    err_en = err;
    send_cmd(a, l);
    send_payload(pay, tog);
  endtask

  task automatic finish_pkt(input bit err);
    int n = 0;
    done_exp++;
    if (err) errs_exp++;
    while (done_seen < done_exp) begin
      @(posedge clock);
      #1;
      if (++n > 1000) begin
        fail_now("done_timeout");
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [1:0] a;
    logic [5:0] l;
    bit e;

    #2;
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_pl_ready", 32'(pl_ready), 0);
    chk("rst_pkt_valid", 32'(pkt_valid), 0);
    chk("rst_pkt_data", 32'(pkt_data), 0);
    chk("rst_done", 32'({done, done_err, cmd_drop}), 0);
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    chk("rel_cmd_ready0", 32'(cmd_ready), 0);
    @(posedge clock);
    #1;
    chk("rel_cmd_ready1", 32'(cmd_ready), 1);

    // basic packet
    pl = '{8'hA1, 8'hB2, 8'hC3};
    start_pkt(2'd1, 6'd3, pl, 1'b0, 1'b0);
    finish_pkt(1'b0);

    // header held by two busy cycles
    start_pkt(2'd1, 6'd3, pl, 1'b0, 1'b0);
    chk("hold_hdr0", 32'({pkt_valid, pkt_data}), 32'h10D);
    busy = 1'b1;
    @(posedge clock);
    #1;
    chk("hold_hdr1", 32'({pkt_valid, pkt_data}), 32'h10D);
    @(posedge clock);
    #1;
    chk("hold_hdr2", 32'({pkt_valid, pkt_data}), 32'h10D);
    busy = 1'b0;
    finish_pkt(1'b0);

    // illegal requests
    send_cmd(2'd3, 6'd5);
    drops_exp++;
    send_cmd(2'd0, 6'd0);
    drops_exp++;
    repeat (2) @(posedge clock);
    #1;
    chk("drop_count", 32'(drops_seen), 32'(drops_exp));
    chk("drop_idle", 32'({cmd_ready, pl_ready}), 32'b10);
    pl = '{8'h5A};
    start_pkt(2'd0, 6'd1, pl, 1'b0, 1'b0);
    finish_pkt(1'b0);

    // maximum length, toggling payload valid
    pl.delete();
    for (int i = 0; i < 63; i++) pl.push_back(8'($urandom));
    start_pkt(2'd2, 6'd63, pl, 1'b1, 1'b0);
    chk("max_hdr", 32'(pkt_data), 32'hFE);
    finish_pkt(1'b0);

    // error during CHK
    pl = '{8'h11, 8'h22};
    start_pkt(2'd0, 6'd2, pl, 1'b0, 1'b1);
    finish_pkt(1'b1);
`ifdef STATS_EN
    #1;
    chk("stat_pkt", 32'(pkt_cnt), 32'(done_exp));
    chk("stat_err", 32'(err_cnt), 32'(errs_exp));
`endif

    // randomised traffic with backpressure and error noise
    busy_rand = 1;
    noise_en = 1;
    for (int k = 0; k < 14; k++) begin
      if ($urandom % 5 == 0) begin
        send_cmd(2'd3, 6'($urandom));
        drops_exp++;
      end
      a = 2'($urandom_range(0, 2));
      l = ($urandom % 6 == 0) ? 6'd63 : 6'($urandom_range(1, 16));
      e = 1'($urandom % 2);
      pl.delete();
      for (int i = 0; i < int'(l); i++) pl.push_back(8'($urandom));
      start_pkt(a, l, pl, 1'($urandom % 2), e);
      finish_pkt(e);
    end
    busy_rand = 0;
    noise_en = 0;
    busy = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("drop_total", 32'(drops_seen), 32'(drops_exp));
`ifdef STATS_EN
    chk("stat_pkt_all", 32'(pkt_cnt), 32'(done_exp));
    chk("stat_err_all", 32'(err_cnt), 32'(errs_exp));
`endif

    // reset in the middle of DATA
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
    start_pkt(2'd1, 6'd20, pl, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("pre_abort_valid", 32'(pkt_valid), 1);
    resetn = 1'b0;
    #1;
    chk("abort_valid", 32'(pkt_valid), 0);
    chk("abort_ready", 32'({cmd_ready, pl_ready}), 0);
    wq.delete();
    eq.delete();
    in_pkt = 0;
    chk_pending = 0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_cmd_ready", 32'(cmd_ready), 1);
    pl = '{8'h3C, 8'hC3, 8'h99, 8'h00};
    start_pkt(2'd2, 6'd4, pl, 1'b0, 1'b0);
    finish_pkt(1'b0);

    repeat (3) @(posedge clock);
    #1;
    chk("wire_left", 32'(wq.size()), 0);
    chk("status_left", 32'(eq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    fail_now("watchdog");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
